// File: rtl/cu_seq_if.sv
// Instruction handshake and RAM/ALU datapath strobes of the cu_seq sequencer.
interface cu_seq_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [4+2*ADDR_W-1:0] instr;
    logic                  flush;
    logic [DATA_W-1:0]     ram_rdata;
    logic                  ram_read;
    logic                  ram_write;
    logic [ADDR_W-1:0]     ram_addr;
    logic [ADDR_W-1:0]     imm;
    logic [1:0]            wb_sel;
    logic                  opa_load;
    logic                  opb_load;
    logic                  alu_enable;
    logic [3:0]            alu_op;
    logic                  done;
    logic                  err;

    modport slave (
        input  instr_valid, instr, flush, ram_rdata,
        output instr_ready, ram_read, ram_write, ram_addr, imm, wb_sel,
               opa_load, opb_load, alu_enable, alu_op, done, err
    );

    modport master (
        output instr_valid, instr, flush, ram_rdata,
        input  instr_ready, ram_read, ram_write, ram_addr, imm, wb_sel,
               opa_load, opb_load, alu_enable, alu_op, done, err
    );
endinterface

// File: rtl/cu_seq.sv
// Multi-cycle control unit: sequences operand reads, ALU execute and RAM writeback
// for one instruction at a time, with flush and illegal-opcode trap.
module cu_seq #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input logic    clk,
    input logic    rst_n,
    cu_seq_if.slave bus
);
    localparam int unsigned OP_W    = 4;
    localparam int unsigned INSTR_W = OP_W + 2*ADDR_W;
    localparam int unsigned CNT_W   = 3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    localparam logic [OP_W-1:0] OP_MOV = 4'b0001;
    localparam logic [OP_W-1:0] OP_MVI = 4'b1100;
    localparam logic [OP_W-1:0] OP_LDA = 4'b1101;

    logic [2:0]         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [INSTR_W-1:0] instr_q, instr_n;
    logic [ADDR_W-1:0]  ptr_q, ptr_n;

    logic              ram_read_q, ram_read_n;
    logic              ram_write_q, ram_write_n;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_n;
    logic [ADDR_W-1:0] imm_q, imm_n;
    logic [1:0]        wb_sel_q, wb_sel_n;
    logic              opa_q, opa_n;
    logic              opb_q, opb_n;
    logic              alu_en_q, alu_en_n;
    logic [3:0]        alu_op_q, alu_op_n;
    logic              done_q, done_n;
    logic              err_q, err_n;

    logic              accept;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] dst, src;
    logic              is_bin, is_un, is_ill;
    logic [DATA_W-1:0] rdata;

    assign rdata  = bus.ram_rdata;
    assign accept = (state == S_IDLE) && !bus.flush && bus.instr_valid;
    assign bus.instr_ready = (state == S_IDLE) && !bus.flush;

    // Decode the instruction being accepted this edge, otherwise the latched one
    assign instr_n = accept ? bus.instr : instr_q;
    assign op      = instr_n[INSTR_W-1 -: OP_W];
    assign dst     = instr_n[2*ADDR_W-1 -: ADDR_W];
    assign src     = instr_n[ADDR_W-1:0];
    assign is_bin  = op inside {4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b1010, 4'b1011};
    assign is_un   = op inside {4'b0111, 4'b1000, 4'b1001};
    assign is_ill  = op inside {4'b0000, 4'b1110, 4'b1111};

    // Outputs are decoded from the next state so every strobe leaves a flop
    always_comb begin
        state_n     = state;
        ptr_n       = ptr_q;
        ram_read_n  = 1'b0;
        ram_write_n = 1'b0;
        ram_addr_n  = '0;
        imm_n       = '0;
        wb_sel_n    = 2'd0;
        opa_n       = 1'b0;
        opb_n       = 1'b0;
        alu_en_n    = 1'b0;
        alu_op_n    = 4'd0;
        done_n      = 1'b0;
        err_n       = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_bin || op == OP_LDA)     state_n = S_RD_A;
                    else if (is_un || op == OP_MOV) state_n = S_RD_B;
                    else                            state_n = S_WB;
                end
            end
            S_RD_A: begin
                if (cnt == CNT_W'(RD_LAT)) begin
                    state_n = S_RD_B;
                    if (op == OP_LDA) ptr_n = ADDR_W'(rdata);
                end
            end
            S_RD_B: begin
                if (cnt == CNT_W'(RD_LAT)) state_n = (is_bin || is_un) ? S_EXEC : S_WB;
            end
            S_EXEC:  state_n = S_WB;
            S_WB:    state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (state != S_IDLE && bus.flush) state_n = S_IDLE;

        cnt_n = (state_n == state && state != S_IDLE) ? cnt + CNT_W'(1) : '0;

        case (state_n)
            S_RD_A: begin
                if (cnt_n == '0) begin
                    ram_read_n = 1'b1;
                    ram_addr_n = (op == OP_LDA) ? src : dst;
                end
                if (cnt_n == CNT_W'(RD_LAT)) opa_n = (op != OP_LDA);
            end
            S_RD_B: begin
                if (cnt_n == '0) begin
                    ram_read_n = 1'b1;
                    ram_addr_n = (op == OP_LDA) ? ptr_n : src;
                end
                if (cnt_n == CNT_W'(RD_LAT)) opb_n = 1'b1;
            end
            S_EXEC: begin
                alu_en_n = 1'b1;
                alu_op_n = op - 4'd1;
            end
            S_WB: begin
                done_n = 1'b1;
                if (is_ill) begin
                    err_n = 1'b1;
                end else begin
                    ram_write_n = 1'b1;
                    ram_addr_n  = dst;
                    if (is_bin || is_un) begin
                        wb_sel_n = 2'd1;
                    end else if (op == OP_MVI) begin
                        wb_sel_n = 2'd2;
                        imm_n    = src;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            instr_q     <= '0;
            ptr_q       <= '0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            imm_q       <= '0;
            wb_sel_q    <= 2'd0;
            opa_q       <= 1'b0;
            opb_q       <= 1'b0;
            alu_en_q    <= 1'b0;
            alu_op_q    <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            instr_q     <= instr_n;
            ptr_q       <= ptr_n;
            ram_read_q  <= ram_read_n;
            ram_write_q <= ram_write_n;
            ram_addr_q  <= ram_addr_n;
            imm_q       <= imm_n;
            wb_sel_q    <= wb_sel_n;
            opa_q       <= opa_n;
            opb_q       <= opb_n;
            alu_en_q    <= alu_en_n;
            alu_op_q    <= alu_op_n;
            done_q      <= done_n;
            err_q       <= err_n;
        end
    end

    assign bus.ram_read   = ram_read_q;
    assign bus.ram_write  = ram_write_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.imm        = imm_q;
    assign bus.wb_sel     = wb_sel_q;
    assign bus.opa_load   = opa_q;
    assign bus.opb_load   = opb_q;
    assign bus.alu_enable = alu_en_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_cu_seq.sv
// Bench for cu_seq: directed scenarios plus random instructions, each checked
// cycle by cycle against an expected strobe trace built from the opcode rules.
module tb_cu_seq;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RD_LAT = 2;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] imm;
        logic [1:0] wb;
        logic       opa;
        logic       opb;
        logic       alu;
        logic [3:0] aop;
        logic       done;
        logic       err;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] mem [256];
    logic       hrd   [RD_LAT+1];
    logic [7:0] haddr [RD_LAT+1];
    obs_t       tr [$];
    obs_t       zero_rec;

    cu_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    cu_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_code(input logic [3:0] op);
        case (op)
            4'b0010: return 4'b0001;  // ADD
            4'b0011: return 4'b0010;  // SUB
            4'b0100: return 4'b0011;  // AND
            4'b0101: return 4'b0100;  // OR
            4'b0110: return 4'b0101;  // XOR
            4'b0111: return 4'b0110;  // NOT
            4'b1000: return 4'b0111;  // SHL
            4'b1001: return 4'b1000;  // SHR
            4'b1010: return 4'b1001;  // LT
            4'b1011: return 4'b1010;  // EQ
            default: return 4'b0000;
        endcase
    endfunction

    // One RAM read phase: strobe with address, RD_LAT-1 quiet cycles, then the load cycle
    function automatic void push_read(input logic [7:0] a, input logic is_a, input logic ld);
        obs_t r;
        r = '0; r.rd = 1'b1; r.addr = a;
        tr.push_back(r);
        for (int k = 1; k < int'(RD_LAT); k++) tr.push_back('0);
        r = '0;
        if (is_a) r.opa = ld; else r.opb = ld;
        tr.push_back(r);
    endfunction

    function automatic void push_exec(input logic [3:0] op);
        obs_t r;
        r = '0; r.alu = 1'b1; r.aop = alu_code(op);
        tr.push_back(r);
    endfunction

    function automatic void push_wb(input logic [7:0] a, input logic [1:0] sel, input logic [7:0] im);
        obs_t r;
        r = '0; r.wr = 1'b1; r.done = 1'b1; r.addr = a; r.wb = sel; r.imm = im;
        tr.push_back(r);
    endfunction

    function automatic void build(input logic [3:0] op, input logic [7:0] dst, input logic [7:0] src);
        obs_t r;
        tr.delete();
        case (op)
            4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b1010, 4'b1011: begin
                push_read(dst, 1'b1, 1'b1);
                push_read(src, 1'b0, 1'b1);
                push_exec(op);
                push_wb(dst, 2'd1, 8'h00);
            end
            4'b0111, 4'b1000, 4'b1001: begin
                push_read(src, 1'b0, 1'b1);
                push_exec(op);
                push_wb(dst, 2'd1, 8'h00);
            end
            4'b0001: begin
                push_read(src, 1'b0, 1'b1);
                push_wb(dst, 2'd0, 8'h00);
            end
            4'b1100: push_wb(dst, 2'd2, src);
            4'b1101: begin
                push_read(src, 1'b1, 1'b0);
                push_read(mem[src], 1'b0, 1'b1);
                push_wb(dst, 2'd0, 8'h00);
            end
            default: begin
                r = '0; r.done = 1'b1; r.err = 1'b1;
                tr.push_back(r);
            end
        endcase
    endfunction

    // Advance to the next falling edge and serve read data RD_LAT cycles after a strobe
    task automatic neg();
        @(negedge clk);
        for (int k = int'(RD_LAT); k > 0; k--) begin
            hrd[k]   = hrd[k-1];
            haddr[k] = haddr[k-1];
        end
        hrd[0]   = bus.ram_read;
        haddr[0] = bus.ram_addr;
        bus.ram_rdata = hrd[RD_LAT] ? mem[haddr[RD_LAT]] : 8'($urandom);
    endtask

    task automatic check(input string tag, input obs_t e, input logic rdy);
        obs_t o;
        o = {bus.ram_read, bus.ram_write, bus.ram_addr, bus.imm, bus.wb_sel, bus.opa_load,
             bus.opb_load, bus.alu_enable, bus.alu_op, bus.done, bus.err};
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s outputs observed=%h expected=%h", tag, o, e);
        end
        checks++;
        assert (bus.instr_ready === rdy) else begin
            failures++;
            $error("FAIL %s instr_ready observed=%b expected=%b", tag, bus.instr_ready, rdy);
        end
    endtask

    // Offer one instruction in an idle cycle and follow its trace; optional flush or reset at a trace index
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [7:0] dst,
                             input logic [7:0] src, input int flush_at, input int rst_at);
        bit flushed = 0;
        bit reset_hit = 0;
        build(op, dst, src);
        bus.instr_valid = 1'b1;
        bus.instr = {op, dst, src};
        for (int i = 0; i < tr.size(); i++) begin
            neg();
            bus.instr_valid = 1'($urandom);
            bus.instr = 20'($urandom);
            check(tag, tr[i], 1'b0);
            if (i == flush_at) begin
                bus.flush = 1'b1;
                flushed = 1;
                break;
            end
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst"}, zero_rec, 1'b1);
                neg();
                check({tag, "_rst_hold"}, zero_rec, 1'b1);
                rst_n = 1'b1;
                reset_hit = 1;
                break;
            end
        end
        neg();
        bus.instr_valid = 1'b0;
        if (flushed) begin
            check({tag, "_flushed"}, zero_rec, 1'b0);
            bus.flush = 1'b0;
            #1;
            check({tag, "_after_flush"}, zero_rec, 1'b1);
        end else begin
            check(reset_hit ? {tag, "_post_rst"} : {tag, "_idle"}, zero_rec, 1'b1);
        end
    endtask

    initial begin
        zero_rec = '0;
        for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
        mem[8'h40] = 8'h77;
        for (int k = 0; k <= int'(RD_LAT); k++) begin hrd[k] = 1'b0; haddr[k] = 8'h00; end
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.flush = 1'b0;
        bus.ram_rdata = '0;
        neg(); neg();
        check("reset", zero_rec, 1'b1);
        rst_n = 1'b1;
        neg();
        check("post_reset", zero_rec, 1'b1);

        run_instr("add", 4'b0010, 8'h10, 8'h11, -1, -1);
        run_instr("mvi", 4'b1100, 8'h20, 8'h5A, -1, -1);
        run_instr("lda", 4'b1101, 8'h30, 8'h40, -1, -1);
        run_instr("ill_1111", 4'b1111, 8'h12, 8'h34, -1, -1);
        run_instr("b2b_or", 4'b0101, 8'h21, 8'h22, -1, -1);
        run_instr("ill_0000", 4'b0000, 8'h55, 8'h66, -1, -1);
        run_instr("mov", 4'b0001, 8'h70, 8'h71, -1, -1);
        run_instr("sub_flush", 4'b0011, 8'h01, 8'h02, int'(RD_LAT) + 1, -1);

        // Flush while idle must hold off a valid instruction
        bus.flush = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr = {4'b1100, 8'h44, 8'h99};
        #1;
        check("idle_flush_ready", zero_rec, 1'b0);
        neg();
        check("idle_flush_block", zero_rec, 1'b0);
        bus.flush = 1'b0;
        run_instr("mvi_after_flush", 4'b1100, 8'h45, 8'h9A, -1, -1);

        run_instr("xor_rst", 4'b0110, 8'h05, 8'h06, -1, 2*(int'(RD_LAT) + 1));
        run_instr("not", 4'b0111, 8'h0A, 8'h0B, -1, -1);

        for (int n = 0; n < 80; n++) begin
            int fa;
            fa = $urandom_range(0, 3 * (2 * (int'(RD_LAT) + 1) + 2));
            if ($urandom_range(0, 3) == 0) begin
                neg();
                check("gap", zero_rec, 1'b1);
            end
            run_instr("rand", 4'($urandom), 8'($urandom), 8'($urandom),
                      ($urandom_range(0, 4) == 0) ? fa : -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cu_seq.md
Name: cu_seq

Overview:
Multi-cycle sequencing control unit, the next generation of the single-cycle opcode decoder. It accepts one instruction at a time over a valid/ready handshake. It steps a state machine through operand reads, ALU execute and RAM writeback, with parametrised address/data width and RAM read latency. It sits between the instruction source and the RAM/ALU datapath, driving all datapath strobes. It adds behaviour the combinational decoder lacks: two-operand reads, indirect load, flush and illegal-opcode trap.

Parameters:
ADDR_W, 8, RAM address width; also the width of the dst/src/immediate fields.
DATA_W, 8, RAM data width; must be >= ADDR_W.
RD_LAT, 1, RAM read latency in cycles; legal range 1..4.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  high = can accept; combinational: (state==IDLE) && !flush
instr  in  4+2*ADDR_W  {opcode[3:0], dst[ADDR_W-1:0], src[ADDR_W-1:0]}
flush  in  1  synchronous abort of the current instruction
ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_read
ram_read  out  1  one-cycle read strobe
ram_write  out  1  one-cycle write strobe
ram_addr  out  ADDR_W  RAM address; 0 when no access
imm  out  ADDR_W  immediate (src field), valid with wb_sel=2
wb_sel  out  2  write source: 0=RAM data, 1=ALU result, 2=immediate
opa_load  out  1  datapath latches ram_rdata into operand A
opb_load  out  1  datapath latches ram_rdata into operand B
alu_enable  out  1  ALU execute strobe
alu_op  out  4  ALU function; 0000 outside EXEC
done  out  1  one-cycle pulse, instruction retired
err  out  1  one-cycle pulse with done, illegal opcode

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, latched instr=0. All registered outputs are 0. instr_ready follows IDLE (1 unless flush).
- Accept on a rising edge where instr_valid && instr_ready. instr is latched at that edge. instr changes after acceptance are ignored.
- States: IDLE, RD_A, RD_B, EXEC, WB.
- A read state lasts RD_LAT+1 cycles:
  - cycle 0: ram_read=1, ram_addr=target address.
  - cycle RD_LAT: the load strobe for that state is 1, then the state advances.
- Opcode routing after acceptance:
  - Binary ADD/SUB/AND/OR/XOR/LT/EQ (0010/0011/0100/0101/0110/1010/1011): RD_A(addr=dst, opa_load) -> RD_B(addr=src, opb_load) -> EXEC -> WB(addr=dst, wb_sel=1).
  - Unary NOT/SHL/SHR (0111/1000/1001): RD_B(addr=src, opb_load) -> EXEC -> WB(addr=dst, wb_sel=1).
  - MOV 0001: RD_B(addr=src, opb_load) -> WB(addr=dst, wb_sel=0).
  - MVI 1100: WB(addr=dst, wb_sel=2, imm=src).
  - LDA 1101 (indirect): RD_A(addr=src; ptr <= ram_rdata[ADDR_W-1:0]; no load strobe) -> RD_B(addr=ptr, opb_load) -> WB(addr=dst, wb_sel=0).
  - Illegal 0000/1110/1111: WB with ram_write=0, err=1.
- ALU mapping in EXEC (one cycle, alu_enable=1): ADD 0001, SUB 0010, AND 0011, OR 0100, XOR 0101, NOT 0110, SHL 0111, SHR 1000, LT 1001, EQ 1010.
- WB is one cycle: ram_write=1 (except illegal), done=1. The next state is IDLE, and a new instruction can be accepted in the cycle after WB.
- Cycles from accept edge to the WB cycle, inclusive:
  - binary: 2*(RD_LAT+1)+2
  - unary: RD_LAT+3
  - MOV: RD_LAT+2
  - LDA: 2*(RD_LAT+1)+1
  - MVI/illegal: 1
- flush=1 in any non-IDLE state: next state IDLE, no further strobes, no done. A strobe already driven in the current cycle (including a WB ram_write) is not retracted. flush=1 in IDLE blocks acceptance.
- All outputs except instr_ready are registered; they never depend combinationally on inputs.
- Reset mid-instruction: immediate return to IDLE with all outputs 0; the instruction is lost.
- The latency counter is sized for RD_LAT max 4 and clears on every state entry.

Test Plan:
- Reset, then ADD (instr=0010,dst=8'h10,src=8'h11), RD_LAT=1 -> read 0x10 in cycle 1, opa_load cycle 2, read 0x11 cycle 3, opb_load cycle 4, alu_enable/alu_op=0001 cycle 5, ram_write/done/addr=0x10/wb_sel=1 cycle 6; instr_ready=0 cycles 1-6.
- MVI dst=0x20 src=0x5A -> next cycle ram_write=1, ram_addr=0x20, wb_sel=2, imm=0x5A, done=1, no ram_read.
- LDA dst=0x30 src=0x40, ram_rdata=0x77 at pointer read, RD_LAT=2 -> reads 0x40 then 0x77 (opb_load on the second read only), write 0x30 wb_sel=0, done in cycle 7.
- Opcode 1111 -> one cycle later done=1, err=1, ram_write=0, no read/ALU strobes; back-to-back valid accepted the following cycle.
- SUB accepted, flush asserted in RD_B -> IDLE next cycle, no alu_enable/ram_write/done; instr_ready=1 after flush drops.
- rst_n low during EXEC of XOR -> all outputs 0 immediately, IDLE, no write; a fresh NOT after release completes in RD_LAT+3 cycles with alu_op=0110.
